// File: rtl/wb_gpio_pkg.sv
// wb_gpio_pkg: register map, default sizes and small mask helpers shared by
// the GPIO slave and its bus wrapper.
package wb_gpio_pkg;

  localparam int DEF_NUM_GPIO    = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_SYNC_STAGES = 2;

  typedef logic [2:0] reg_idx_t;

  localparam reg_idx_t GPIO_IN      = 3'd0;
  localparam reg_idx_t GPIO_OUT     = 3'd1;
  localparam reg_idx_t GPIO_DIR     = 3'd2;
  localparam reg_idx_t GPIO_SET     = 3'd3;
  localparam reg_idx_t GPIO_CLR     = 3'd4;
  localparam reg_idx_t GPIO_RISE_EN = 3'd5;
  localparam reg_idx_t GPIO_FALL_EN = 3'd6;
  localparam reg_idx_t GPIO_STAT    = 3'd7;

  // Ones in the low n bit positions: the pins that actually exist.
  function automatic logic [31:0] pin_mask(input int n);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  // Expand the four byte selects into a 32-bit write mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/wb_gpio_if.sv
// wb_if: classic Wishbone slave-port bundle shared by the *_w wrappers.
interface wb_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;

  modport master (output adr, dat_w, sel, we, cyc, stb, input dat_r, ack, err);
  modport slave  (input adr, dat_w, sel, we, cyc, stb, output dat_r, ack, err);
endinterface

// File: rtl/wb_gpio_w.sv
// wb_gpio_w: maps a wb_if slave modport onto the flat ports of wb_gpio.
module wb_gpio_w
  import wb_gpio_pkg::*;
#(
  parameter int          NUM_GPIO     = DEF_NUM_GPIO,
  parameter int          SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter logic [31:0] RESET_OUT    = 32'h0,
  parameter logic [31:0] RESET_DIR    = 32'h0,
  parameter int          DEBOUNCE_DIV = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  wb_if.slave                 s,
  input  logic [NUM_GPIO-1:0] gpio_i,
  output logic [NUM_GPIO-1:0] gpio_o,
  output logic [NUM_GPIO-1:0] gpio_oe,
  output logic                irq_o
);

  wb_gpio #(
    .NUM_GPIO    (NUM_GPIO),
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_OUT   (RESET_OUT),
    .RESET_DIR   (RESET_DIR),
    .DEBOUNCE_DIV(DEBOUNCE_DIV)
  ) u_gpio (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .adr_i  (s.adr),
    .dat_i  (s.dat_w),
    .dat_o  (s.dat_r),
    .sel_i  (s.sel),
    .we_i   (s.we),
    .cyc_i  (s.cyc),
    .stb_i  (s.stb),
    .ack_o  (s.ack),
    .err_o  (s.err),
    .gpio_i (gpio_i),
    .gpio_o (gpio_o),
    .gpio_oe(gpio_oe),
    .irq_o  (irq_o)
  );

endmodule

// File: rtl/wb_gpio.sv
// wb_gpio: Wishbone GPIO slave with per-pin direction, atomic set/clear,
// synchronised inputs and rise/fall edge capture into a W1C status register.
// Optional input debounce is built when WB_GPIO_DEBOUNCE_EN is defined.
module wb_gpio
  import wb_gpio_pkg::*;
#(
  parameter int          NUM_GPIO     = DEF_NUM_GPIO,
  parameter int          SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter logic [31:0] RESET_OUT    = 32'h0,
  parameter logic [31:0] RESET_DIR    = 32'h0,
  parameter int          DEBOUNCE_DIV = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         adr_i,
  input  logic [31:0]         dat_i,
  output logic [31:0]         dat_o,
  input  logic [3:0]          sel_i,
  input  logic                we_i,
  input  logic                cyc_i,
  input  logic                stb_i,
  output logic                ack_o,
  output logic                err_o,
  input  logic [NUM_GPIO-1:0] gpio_i,
  output logic [NUM_GPIO-1:0] gpio_o,
  output logic [NUM_GPIO-1:0] gpio_oe,
  output logic                irq_o
);

  localparam logic [31:0] PIN_MASK = pin_mask(NUM_GPIO);

  logic [NUM_GPIO-1:0] r_sync [SYNC_STAGES];
  logic [NUM_GPIO-1:0] w_in;
  logic [NUM_GPIO-1:0] r_prev;
  logic [31:0]         w_in32, w_prev32, w_edge32, w_rdata, w_w1c;
  logic [31:0]         r_out, r_dir, r_rise, r_fall, r_stat, r_dat;
  logic [31:0]         w_wmask, w_wdat;
  logic                r_ack, r_primed;
  logic [2:0]          r_prime_cnt;
  logic                w_req, w_wr;
  reg_idx_t            w_idx;
  logic                w_unused;

  assign w_req    = cyc_i & stb_i & ~r_ack;
  assign w_wr     = w_req & we_i;
  assign w_idx    = reg_idx_t'(adr_i[4:2]);
  assign w_wmask  = lane_mask(sel_i) & PIN_MASK;
  assign w_wdat   = dat_i & w_wmask;
  assign w_unused = ^{adr_i[31:5], adr_i[1:0]};

  // Input synchroniser chain: stage 0 samples the asynchronous pads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

`ifdef WB_GPIO_DEBOUNCE_EN
  localparam int PRE_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
  logic [PRE_W-1:0]    r_pre;
  logic                w_tick;
  logic [1:0]          r_cnt [NUM_GPIO];
  logic [NUM_GPIO-1:0] r_deb;

  assign w_tick = (r_pre == PRE_W'(DEBOUNCE_DIV - 1));

  // Shared prescaler producing one tick per DEBOUNCE_DIV cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Per-pin debounce: a level must disagree on four consecutive ticks to be accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_GPIO; i++) r_cnt[i] <= 2'd0;
      r_deb <= '0;
    end else if (w_tick) begin
      for (int i = 0; i < NUM_GPIO; i++) begin
        if (r_sync[SYNC_STAGES-1][i] != r_deb[i]) begin
          if (r_cnt[i] == 2'd3) begin
            r_deb[i] <= r_sync[SYNC_STAGES-1][i];
            r_cnt[i] <= 2'd0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 2'd1;
          end
        end else begin
          r_cnt[i] <= 2'd0;
        end
      end
    end
  end

  assign w_in = r_deb;
`else
  localparam int unused_debounce_div = DEBOUNCE_DIV;
  assign w_in = r_sync[SYNC_STAGES-1];
`endif

  // Zero-extend pin vectors to the 32-bit register width.
  always_comb begin
    w_in32   = 32'h0;
    w_prev32 = 32'h0;
    w_in32[NUM_GPIO-1:0]   = w_in;
    w_prev32[NUM_GPIO-1:0] = r_prev;
  end

  // Edge qualification; held off until the synchroniser has flushed power-up levels.
  always_comb begin
    w_edge32 = 32'h0;
    if (r_primed) begin
      w_edge32 = ((r_rise & w_in32 & ~w_prev32) | (r_fall & ~w_in32 & w_prev32)) & PIN_MASK;
    end else begin
      w_edge32 = 32'h0;
    end
  end

  // Bits cleared by a write-one-to-clear access to STAT this cycle.
  always_comb begin
    w_w1c = 32'h0;
    if (w_wr && (w_idx == GPIO_STAT)) begin
      w_w1c = w_wdat;
    end else begin
      w_w1c = 32'h0;
    end
  end

  // Read data selection; write-only registers read as zero.
  always_comb begin
    w_rdata = 32'h0;
    case (w_idx)
      GPIO_IN:      w_rdata = w_in32;
      GPIO_OUT:     w_rdata = r_out;
      GPIO_DIR:     w_rdata = r_dir;
      GPIO_SET:     w_rdata = 32'h0;
      GPIO_CLR:     w_rdata = 32'h0;
      GPIO_RISE_EN: w_rdata = r_rise;
      GPIO_FALL_EN: w_rdata = r_fall;
      GPIO_STAT:    w_rdata = r_stat;
      default:      w_rdata = 32'h0;
    endcase
  end

  // Power-up priming counter: detection enabled SYNC_STAGES+1 cycles after reset release.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prime_cnt <= 3'd0;
      r_primed    <= 1'b0;
    end else if (!r_primed) begin
      r_prime_cnt <= r_prime_cnt + 3'd1;
      r_primed    <= (r_prime_cnt == 3'(SYNC_STAGES));
    end
  end

  // Bus handshake, register writes and status capture (a new edge beats W1C).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack  <= 1'b0;
      r_dat  <= 32'h0;
      r_out  <= RESET_OUT & PIN_MASK;
      r_dir  <= RESET_DIR & PIN_MASK;
      r_rise <= 32'h0;
      r_fall <= 32'h0;
      r_stat <= 32'h0;
      r_prev <= '0;
    end else begin
      r_ack  <= w_req;
      r_prev <= w_in;
      r_stat <= (r_stat & ~w_w1c) | w_edge32;
      if (w_req) begin
        r_dat <= w_rdata;
      end
      if (w_wr) begin
        case (w_idx)
          GPIO_OUT:     r_out  <= (r_out & ~w_wmask) | w_wdat;
          GPIO_DIR:     r_dir  <= (r_dir & ~w_wmask) | w_wdat;
          GPIO_SET:     r_out  <= r_out | w_wdat;
          GPIO_CLR:     r_out  <= r_out & ~w_wdat;
          GPIO_RISE_EN: r_rise <= (r_rise & ~w_wmask) | w_wdat;
          GPIO_FALL_EN: r_fall <= (r_fall & ~w_wmask) | w_wdat;
          default:      ;
        endcase
      end
    end
  end

  assign dat_o   = r_dat;
  assign ack_o   = r_ack;
  assign err_o   = 1'b0;
  assign gpio_o  = r_out[NUM_GPIO-1:0];
  assign gpio_oe = r_dir[NUM_GPIO-1:0];
  assign irq_o   = |r_stat;

endmodule

// File: doc/wb_gpio.md
Name: wb_gpio

Overview:
- Parametrised Wishbone GPIO slave. It replaces the fixed 4-bit write-only pad latch in the SoC top.
- Provides up to 32 pins, each with per-pin direction, atomic set/clear, and synchronised inputs.
- Provides per-pin rising/falling-edge interrupt capture with a single aggregated level interrupt to simple_pic_w.
- Sits on one interconnect slave port (4 KB window); only adr[4:2] is decoded.

Parameters:
- NUM_GPIO, 32, number of pins (1..32); register bits at and above NUM_GPIO read 0 and ignore writes.
- SYNC_STAGES, 2, input synchroniser depth (2..4).
- RESET_OUT, 32'h0, reset value of OUT.
- RESET_DIR, 32'h0, reset value of DIR (1 = output).
- DEBOUNCE_DIV, 1024, prescaler period in clk_i cycles (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- adr_i  in  32  Wishbone address (only [4:2] decoded)
- dat_i  in  32  write data
- dat_o  out  32  read data, registered
- sel_i  in  4  byte selects
- we_i  in  1  write enable
- cyc_i  in  1  bus cycle
- stb_i  in  1  strobe
- ack_o  out  1  acknowledge
- err_o  out  1  tied 0
- gpio_i  in  NUM_GPIO  pad inputs (asynchronous)
- gpio_o  out  NUM_GPIO  pad output values = OUT
- gpio_oe  out  NUM_GPIO  pad output enables = DIR
- irq_o  out  1  level interrupt = OR of STAT

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - OUT=RESET_OUT, DIR=RESET_DIR; RISE_EN, FALL_EN, STAT, sync chain, prev, dat_o all 0.
  - ack_o=0, irq_o=0, primed=0.
- Register map (adr[4:2]):
  - 0 IN (RO): synchronised pins.
  - 1 OUT (RW).
  - 2 DIR (RW).
  - 3 SET (WO): OUT |= data. Reads 0.
  - 4 CLR (WO): OUT &= ~data. Reads 0.
  - 5 RISE_EN (RW).
  - 6 FALL_EN (RW).
  - 7 STAT (R/W1C).
- Byte lanes:
  - Writes honour sel_i per byte on every writable register.
  - sel_i=0 writes nothing but is still acked.
- Handshake:
  - When cyc_i&stb_i&!ack_o, ack_o=1 on the next edge for exactly one cycle. dat_o is valid in that same cycle.
  - The write takes effect at the edge that raises ack_o.
  - Back-to-back requests give ack every other cycle.
  - If cyc_i drops before ack, no write occurs and no ack is issued.
- Input path:
  - gpio_i passes through SYNC_STAGES flops; the last stage is IN.
  - A pin change captured at edge N appears in IN after edge N+SYNC_STAGES-1.
- Edge detect:
  - prev <= IN every cycle.
  - STAT[i] set at the next edge when (RISE_EN[i]&IN[i]&!prev[i]) | (FALL_EN[i]&!IN[i]&prev[i]).
  - Detection is independent of DIR, so output pins looped back also interrupt.
- Priming:
  - Detection is suppressed until primed=1.
  - primed sets SYNC_STAGES+1 cycles after reset release, so power-up pin levels never latch STAT.
- Simultaneous events on the same STAT bit:
  - W1C and a new edge in the same cycle: the bit stays 1 (set wins).
  - SET and CLR cannot coincide, because only one access is in flight.
- irq_o is the combinational OR of the STAT flops, so it rises in the same cycle as STAT.
- Reset during an access: ack_o forced 0 and the access is dropped.
- Unused upper pins: gpio_o/gpio_oe bits absent, STAT bits constant 0.

Optional Feature:
- Macro: WB_GPIO_DEBOUNCE_EN.
- When defined:
  - A shared prescaler counts 0..DEBOUNCE_DIV-1 and emits a tick on wrap.
  - Each pin has a 2-bit counter. On a tick, if sync≠deb then cnt++, else cnt=0.
  - When cnt reaches 3 and sync≠deb on a tick: deb<=sync, cnt=0.
  - IN and edge detect use deb. Added latency is 3 to 4 ticks. Reset clears the prescaler and counters and sets deb=0.
- When undefined: no prescaler or counters exist, and IN is the synchroniser output.

Decomposition:
- Package wb_gpio_pkg holds:
  - Register offset localparams (GPIO_IN=3'd0 … GPIO_STAT=3'd7).
  - Default widths.
  - A typedef for the 3-bit register index.
- Sub-module wb_gpio_w: thin wrapper mapping a wb_if slave modport (s) onto wb_gpio's flat ports, consistent with the other *_w wrappers.
- The synchroniser/debounce is small enough to stay in wb_gpio.

Test Plan:
- Reset with RESET_OUT=32'hA5, RESET_DIR=32'hFF → read OUT=0xA5, DIR=0xFF, STAT=0; gpio_o=0xA5; irq_o=0.
- Write OUT=0x0F; write SET=0xF0; write CLR=0x03 → OUT reads 0xFC, gpio_o=0xFC; each access acks after exactly 1 cycle.
- Write OUT=0xFFFFFFFF with sel_i=4'b0010 starting from OUT=0 → OUT=0x0000FF00.
- RISE_EN=0x1, drive gpio_i[0] 0→1 → IN[0]=1 after SYNC_STAGES-1 edges; STAT=0x1 and irq_o=1 one edge later. Falling edge with FALL_EN=0 → no change. W1C 0x1 → irq_o=0.
- Pin toggle timed so the edge lands in the same cycle as a W1C of that bit → STAT[0] remains 1.
- With gpio_i[3]=1 held through reset and RISE_EN=0x8 written immediately after release → STAT stays 0. With WB_GPIO_DEBOUNCE_EN and DEBOUNCE_DIV=4, a 5-cycle glitch on pin 3 leaves IN[3] unchanged.
